laser310_bank_ctrl: RTL and testbench

LASER310_BANK_CTRL -- requirements
Module: laser310_bank_ctrl

---
 rtl/laser310_pkg.sv | 17 +
 rtl/z80_strobe_sync.sv | 26 ++
 rtl/laser310_bank_ctrl.sv | 116 +++++++++++
 tb/tb_laser310_bank_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/laser310_pkg.sv
// Shared types and default constants for the Laser 310 RAM bank controller.
package laser310_pkg;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } bank_state_t;

    localparam logic [3:0] IO_PORT_DFLT = 4'h7;
    localparam logic [4:0] WIN_LO_DFLT  = 5'b10111;

    // Edges the ARM state waits for the synchroniser to reflect the real pins.
    localparam logic [1:0] ARM_FLUSH    = 2'd2;

endpackage

// File: rtl/z80_strobe_sync.sv
// Two-flop synchroniser for the active-low Z80 bus strobes; idles high.
module z80_strobe_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule

// File: rtl/laser310_bank_ctrl.sv
// Laser 310 RAM expansion: Z80 OUT-port bank register with lock bit and
// combinational RAM chip/address decode.
//
// state  | meaning
// ARM    | after reset; wait for the synchroniser to flush and IORQ to go idle
// IDLE   | waiting for a valid write to the bank port
// COMMIT | bank/lock updated on entry; lasts one cycle
// HOLD   | waiting for the current I/O cycle to end
module laser310_bank_ctrl
    import laser310_pkg::*;
#(
    parameter int         BANK_BITS  = 2,
    parameter logic [3:0] IO_PORT    = IO_PORT_DFLT,
    parameter logic [4:0] WIN_LO     = WIN_LO_DFLT,
    parameter int         FIXED_PAGE = 0,
    parameter int         RESET_BANK = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           addr_hi,
    input  logic [3:0]           addr_io,
    input  logic                 wr_n,
    input  logic                 rd_n,
    input  logic                 mreq_n,
    input  logic                 iorq_n,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [BANK_BITS-1:0] ram_ahi,
    output logic                 ram_cs_n,
    output logic                 ram_oe_n,
    output logic                 ram_we_n,
    output logic                 led_cs,
    output logic                 led_we
);

    localparam logic [BANK_BITS-1:0] W_FIXED = BANK_BITS'(FIXED_PAGE);
    localparam logic [BANK_BITS-1:0] W_RST   = BANK_BITS'(RESET_BANK);

    logic [3:0]           w_strb_s;
    logic                 w_wr_s, w_rd_s, w_mreq_s, w_iorq_s;
    logic                 w_valid_wr;
    logic                 w_commit;
    logic                 w_cs;
    bank_state_t          r_state, w_state_nxt;
    logic [1:0]           r_arm_cnt;
    logic [7:0]           r_data;
    logic [BANK_BITS-1:0] r_bank;
    logic                 r_lock;

    z80_strobe_sync #(.WIDTH(4)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in ({wr_n, rd_n, mreq_n, iorq_n}),
        .sync_out (w_strb_s)
    );

    assign {w_wr_s, w_rd_s, w_mreq_s, w_iorq_s} = w_strb_s;

    assign w_valid_wr = !w_iorq_s && w_mreq_s && !w_wr_s && w_rd_s && (addr_io == IO_PORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= ARM_FLUSH;
            r_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= data_in;
            if (r_state == ST_ARM && r_arm_cnt != 2'd0)
                r_arm_cnt <= r_arm_cnt - 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_ARM:    if (r_arm_cnt == 2'd0 && w_iorq_s) w_state_nxt = ST_IDLE;
            ST_IDLE:   if (w_valid_wr) begin
                           w_state_nxt = ST_COMMIT;
                           w_commit    = 1'b1;
                       end
            ST_COMMIT: w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_iorq_s) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_ARM;
        endcase
    end

    // Once locked, the bank value is frozen until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= W_RST;
            r_lock <= 1'b0;
        end else if (w_commit && !r_lock) begin
            r_bank <= r_data[BANK_BITS-1:0];
            r_lock <= r_data[7];
        end
    end

    assign w_cs     = !mreq_n && iorq_n && (wr_n ^ rd_n) && (addr_hi >= WIN_LO);
    assign ram_cs_n = !w_cs;
    assign ram_oe_n = ram_cs_n | ~wr_n;
    assign ram_we_n = ram_cs_n | wr_n;
    assign led_cs   = ~ram_cs_n;
    assign led_we   = ~ram_we_n;
    assign ram_ahi  = (addr_hi == WIN_LO) ? W_FIXED : r_bank;
    assign data_oe  = !iorq_n && mreq_n && !rd_n && wr_n && (addr_io == IO_PORT);

    always_comb begin
        data_out                = '0;
        data_out[7]             = r_lock;
        data_out[BANK_BITS-1:0] = r_bank;
    end

endmodule

// File: tb/tb_laser310_bank_ctrl.sv
// Directed bench for laser310_bank_ctrl: bank port writes, lock, decode, reset.
module tb_laser310_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] addr_hi;
    logic [3:0] addr_io;
    logic       wr_n, rd_n, mreq_n, iorq_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic [1:0] ram_ahi;
    logic       ram_cs_n, ram_oe_n, ram_we_n;
    logic       led_cs, led_we;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    laser310_bank_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_hi  (addr_hi),
        .addr_io  (addr_io),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .ram_ahi  (ram_ahi),
        .ram_cs_n (ram_cs_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n),
        .led_cs   (led_cs),
        .led_we   (led_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        wr_n = 1'b1; rd_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    endtask

    task automatic io_wr(input logic [3:0] port, input logic [7:0] val, input int hold);
        @(negedge clk);
        addr_io = port; data_in = val;
        iorq_n = 1'b0; wr_n = 1'b0;
        cyc(hold);
        bus_idle();
        cyc(4);
    endtask

    initial begin
        rst_n = 1'b0; addr_hi = 5'b00000; addr_io = 4'h0; data_in = 8'h00;
        bus_idle();
        cyc(3);
        chk("rst_cs_n",   ram_cs_n, 1);
        chk("rst_oe_n",   ram_oe_n, 1);
        chk("rst_we_n",   ram_we_n, 1);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_data_out", data_out, 8'h01);
        chk("rst_ram_ahi", ram_ahi, 1);
        chk("rst_leds",   {led_cs, led_we}, 2'b00);

        rst_n = 1'b1;
        cyc(5);
        addr_hi = 5'b11000; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("rd_ahi",  ram_ahi, 1);
        chk("rd_cs_n", ram_cs_n, 0);
        chk("rd_oe_n", ram_oe_n, 0);
        chk("rd_we_n", ram_we_n, 1);
        chk("rd_led_cs", led_cs, 1);
        cyc(1); bus_idle();

        // OUT (0x70),0x02: visible on ram_ahi within 4 clk edges
        cyc(1);
        addr_io = 4'h7; data_in = 8'h02; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("out02_ahi_4clk", ram_ahi, 2);
        cyc(2); bus_idle(); cyc(4);
        chk("out02_data_out", data_out, 8'h02);

        addr_hi = 5'b10111; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("fixed_ahi", ram_ahi, 0);
        chk("fixed_cs_n", ram_cs_n, 0);
        cyc(1); bus_idle();
        addr_hi = 5'b11111; mreq_n = 1'b0; wr_n = 1'b0;
        #1;
        chk("mwr_ahi", ram_ahi, 2);
        chk("mwr_oe_we", {ram_oe_n, ram_we_n}, 2'b10);
        chk("mwr_led_we", led_we, 1);
        addr_hi = 5'b10110;
        #1;
        chk("below_win_cs_n", ram_cs_n, 1);
        cyc(1); bus_idle(); cyc(2);

        // Long I/O cycle: data changes mid-cycle must not cause a second commit
        @(negedge clk);
        addr_io = 4'h7; data_in = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        cyc(8);
        data_in = 8'h03;
        cyc(12);
        bus_idle(); cyc(4);
        chk("long_hold_bank", data_out, 8'h01);

        // Illegal strobe combinations
        addr_hi = 5'b11000; addr_io = 4'h7; data_in = 8'h03;
        mreq_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        #1;
        chk("mreq_iorq_cs_n", ram_cs_n, 1);
        cyc(6); bus_idle(); cyc(4);
        chk("mreq_iorq_nochg", data_out, 8'h01);
        mreq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("wr_rd_cs_n", ram_cs_n, 1);
        cyc(1); bus_idle();
        iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
        cyc(6); bus_idle(); cyc(4);
        chk("io_wr_rd_nochg", data_out, 8'h01);
        io_wr(4'h6, 8'h02, 4);
        chk("wrong_port_nochg", data_out, 8'h01);

        io_wr(4'h7, 8'h00, 3);
        chk("bank0_data_out", data_out, 8'h00);
        addr_hi = 5'b11000;
        #1;
        chk("bank0_ahi", ram_ahi, 0);

        io_wr(4'h7, 8'h83, 3);
        chk("lock_set", data_out, 8'h83);
        chk("lock_ahi", ram_ahi, 3);
        io_wr(4'h7, 8'h01, 3);
        chk("lock_hold", data_out, 8'h83);
        addr_io = 4'h7; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("in_data_oe", data_oe, 1);
        chk("in_data_out", data_out, 8'h83);
        addr_io = 4'h6;
        #1;
        chk("in_wrong_port_oe", data_oe, 0);
        cyc(1); bus_idle(); cyc(3);

        // Reset during an OUT 0x02 must not commit it after release
        @(negedge clk);
        addr_io = 4'h7; data_in = 8'h02; iorq_n = 1'b0; wr_n = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        cyc(2);
        chk("midrst_data_out", data_out, 8'h01);
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_nocommit", data_out, 8'h01);
        bus_idle(); cyc(4);
        chk("post_rst_idle", data_out, 8'h01);
        io_wr(4'h7, 8'h02, 3);
        chk("post_rst_next_io", data_out, 8'h02);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
